pa_swr_monitor: RTL and testbench
=================================

Name: pa_swr_monitor

Overview:
- Downstream consumer of the MCP3204 auxiliary-ADC reader: takes the 12-bit forward-power (AIN1) and reverse-power (AIN2) words.
- Produces smoothed readings, a forward-power peak-hold value for telemetry, and a latched high-SWR trip with transmit lockout for PA protection.
- Samples at a fixed, parameterised rate. No handshake exists with the ADC reader; its output registers are simply re-read every sample tick.

Parameters:
SAMPLE_DIV, 16'd1000, clock cycles between sample ticks (>=2)
AVG_SHIFT, 3, IIR smoothing shift (alpha = 2^-AVG_SHIFT)
HOLD_SAMPLES, 500, ticks a new peak is held before decay starts
DECAY_STEP, 8, LSBs subtracted from peak per tick during decay
FWD_MIN, 12'd100, minimum fwd_avg for SWR evaluation
TRIP_SHIFT, 1, trip when (rev_avg << TRIP_SHIFT) >= fwd_avg
TRIP_COUNT, 4, consecutive bad evaluations required to trip
LOCKOUT_SAMPLES, 1000, ticks of enforced inhibit after trip clears

Ports:
clock  in  1  system clock; one clock domain, no CDC
reset_n  in  1  asynchronous active-low reset
ptt  in  1  transmit request, synchronous to clock
fwd_in  in  12  forward-power ADC word (AIN1)
rev_in  in  12  reverse-power ADC word (AIN2)
fwd_avg  out  12  smoothed forward power
rev_avg  out  12  smoothed reverse power
fwd_peak  out  12  forward peak-hold with decay
sample_strobe  out  1  one-cycle pulse, outputs just updated
swr_trip  out  1  high-SWR fault latched
tx_inhibit  out  1  PA keying must be blocked

Behaviour:
- Reset (reset_n low, asynchronous):
  - All outputs 0; accumulators, counters and hold/lock counters cleared; FSM state = IDLE.
  - Deassertion mid-sample restarts the divider from 0.
- Tick generation:
  - Divider counts 0..SAMPLE_DIV-1; the tick is the cycle where count == SAMPLE_DIV-1, after which the count wraps to 0.
  - fwd_in and rev_in are captured on the tick edge.
  - All derived outputs update on that edge; sample_strobe is high for exactly the following cycle, coincident with the new values.
- Averaging:
  - Per channel, accumulator acc is (12+AVG_SHIFT) bits: acc <= acc - (acc >> AVG_SHIFT) + x.
  - avg = acc >> AVG_SHIFT. Cannot overflow; for constant x, avg converges to x.
- Peak hold:
  - If fwd_in >= fwd_peak: fwd_peak <= fwd_in, hold_cnt <= HOLD_SAMPLES.
  - Else if hold_cnt != 0: hold_cnt decrements.
  - Else fwd_peak <= fwd_peak - DECAY_STEP, saturating at 0.
- SWR evaluation (on ticks, TX state only):
  - Uses the fwd_avg/rev_avg values registered before this tick's update.
  - bad = fwd_avg >= FWD_MIN and (rev_avg << TRIP_SHIFT) >= fwd_avg, compared at 12+TRIP_SHIFT bits unsigned.
  - bad increments bad_cnt (saturating); not bad clears it. bad_cnt is cleared on any state exit.
- FSM (evaluated every clock; counters move only on ticks):
  - IDLE: ptt=1 -> TX.
  - TX: ptt=0 -> IDLE. bad_cnt reaching TRIP_COUNT on a tick -> TRIPPED on that same edge. If both occur on one edge, TRIPPED wins.
  - TRIPPED: ptt=0 -> LOCKOUT, lock_cnt <= LOCKOUT_SAMPLES.
  - LOCKOUT: lock_cnt decrements per tick; the tick at which lock_cnt == 1 -> IDLE. ptt is ignored while in LOCKOUT. If ptt=1 on exit, go to TX next cycle via IDLE.
- Outputs decoded from registered state:
  - swr_trip = (state == TRIPPED).
  - tx_inhibit = (state == TRIPPED or LOCKOUT).
- Averaging and peak hold run in every state, independent of ptt.

Test Plan:
Common bench parameters: SAMPLE_DIV=4, AVG_SHIFT=2, HOLD_SAMPLES=3, DECAY_STEP=8, FWD_MIN=100, TRIP_SHIFT=1, TRIP_COUNT=4, LOCKOUT_SAMPLES=5.
- Reset: drive nonzero inputs with ptt=1, pulse reset_n low mid-period -> all outputs 0 immediately (asynchronous); first sample_strobe 4 cycles after release.
- Averaging step: fwd_in 0 -> 400 held -> fwd_avg reads 100, 175, 231, 273 on successive strobes, settling at 400; rev_in=0 keeps rev_avg=0.
- Peak hold: fwd_in=1000 for one tick, then 0 -> fwd_peak 1000 for the strobe plus 3 further strobes, then 992, 984, ...; saturates at 0 and never wraps.
- Trip: ptt=1, fwd_in=2000, rev_in=1200 from reset -> bad on strobes 2-5; swr_trip and tx_inhibit rise coincident with the 5th sample_strobe.
- Lockout: after the trip, drop ptt for 1 cycle, then hold ptt=1 -> swr_trip falls, tx_inhibit stays high for exactly 5 ticks, then state goes IDLE -> TX with tx_inhibit=0.
- No false trip:
  - fwd_in=2000, rev_in=200 -> never trips.
  - fwd_in=rev_in=300 with FWD_MIN=400 -> never trips.
  - ptt toggling every 3 ticks with bad inputs -> bad_cnt keeps clearing, no trip.

Source files
------------

// File: rtl/pa_swr_monitor.sv
// rtl/pa_swr_monitor.sv - PA forward/reverse power smoothing, peak hold and high-SWR trip/lockout
module pa_swr_monitor #(
  parameter logic [15:0] SAMPLE_DIV      = 16'd1000,
  parameter int          AVG_SHIFT       = 3,
  parameter int          HOLD_SAMPLES    = 500,
  parameter int          DECAY_STEP      = 8,
  parameter logic [11:0] FWD_MIN         = 12'd100,
  parameter int          TRIP_SHIFT      = 1,
  parameter int          TRIP_COUNT      = 4,
  parameter int          LOCKOUT_SAMPLES = 1000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ptt,
  input  logic [11:0] fwd_in,
  input  logic [11:0] rev_in,
  output logic [11:0] fwd_avg,
  output logic [11:0] rev_avg,
  output logic [11:0] fwd_peak,
  output logic        sample_strobe,
  output logic        swr_trip,
  output logic        tx_inhibit
);

  localparam int AW = 12 + AVG_SHIFT;
  localparam int CW = 12 + TRIP_SHIFT;

  typedef enum logic [1:0] {IDLE, TX, TRIPPED, LOCKOUT} state_t;

  state_t        state, state_next;
  logic [15:0]   div_cnt;
  logic          tick;
  logic [AW-1:0] fwd_acc, rev_acc, fwd_acc_next, rev_acc_next;
  logic [15:0]   hold_cnt;
  logic [15:0]   lock_cnt, lock_next;
  logic [7:0]    bad_cnt, bad_inc, bad_keep;
  logic [CW-1:0] rev_scaled, fwd_ext;
  logic          bad;

  assign tick = (div_cnt == SAMPLE_DIV - 16'd1);

  // The accumulator holds avg scaled by 2^AVG_SHIFT, so it cannot overflow AW bits.
  assign fwd_acc_next = fwd_acc - (fwd_acc >> AVG_SHIFT) + AW'(fwd_in);
  assign rev_acc_next = rev_acc - (rev_acc >> AVG_SHIFT) + AW'(rev_in);

  assign rev_scaled = CW'(rev_avg) << TRIP_SHIFT;
  assign fwd_ext    = CW'(fwd_avg);
  assign bad        = (fwd_avg >= FWD_MIN) && (rev_scaled >= fwd_ext);
  assign bad_inc    = bad ? ((bad_cnt == 8'hFF) ? bad_cnt : bad_cnt + 8'd1) : 8'd0;

  always_comb begin
    state_next = state;
    lock_next  = lock_cnt;
    bad_keep   = bad_cnt;
    case (state)
      IDLE: if (ptt) state_next = TX;
      TX: begin
        if (tick) bad_keep = bad_inc;
        if (tick && (bad_inc >= 8'(TRIP_COUNT))) state_next = TRIPPED;
        else if (!ptt)                           state_next = IDLE;
      end
      TRIPPED: if (!ptt) begin
        state_next = LOCKOUT;
        lock_next  = 16'(LOCKOUT_SAMPLES);
      end
      LOCKOUT: if (tick) begin
        if (lock_cnt == 16'd1) begin
          state_next = IDLE;
          lock_next  = 16'd0;
        end else begin
          lock_next = lock_cnt - 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (state_next != state) bad_keep = 8'd0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt       <= '0;
      sample_strobe <= 1'b0;
      fwd_acc       <= '0;
      rev_acc       <= '0;
      fwd_avg       <= '0;
      rev_avg       <= '0;
      fwd_peak      <= '0;
      hold_cnt      <= '0;
      state         <= IDLE;
      lock_cnt      <= '0;
      bad_cnt       <= '0;
      swr_trip      <= 1'b0;
      tx_inhibit    <= 1'b0;
    end else begin
      div_cnt       <= tick ? 16'd0 : div_cnt + 16'd1;
      sample_strobe <= tick;
      if (tick) begin
        fwd_acc <= fwd_acc_next;
        rev_acc <= rev_acc_next;
        fwd_avg <= fwd_acc_next[AW-1:AVG_SHIFT];
        rev_avg <= rev_acc_next[AW-1:AVG_SHIFT];
        if (fwd_in >= fwd_peak) begin
          fwd_peak <= fwd_in;
          hold_cnt <= 16'(HOLD_SAMPLES);
        end else if (hold_cnt != 16'd0) begin
          hold_cnt <= hold_cnt - 16'd1;
        end else if (fwd_peak < 12'(DECAY_STEP)) begin
          fwd_peak <= 12'd0;
        end else begin
          fwd_peak <= fwd_peak - 12'(DECAY_STEP);
        end
      end
      // Status flags follow the next state so they line up with the registered state.
      state      <= state_next;
      lock_cnt   <= lock_next;
      bad_cnt    <= bad_keep;
      swr_trip   <= (state_next == TRIPPED);
      tx_inhibit <= (state_next == TRIPPED) || (state_next == LOCKOUT);
    end
  end

endmodule

// File: tb/tb_pa_swr_monitor.sv
// tb/tb_pa_swr_monitor.sv - directed self-checking bench for pa_swr_monitor
module tb_pa_swr_monitor;

  logic        clock, reset_n, ptt;
  logic [11:0] fwd_in, rev_in;
  logic [11:0] fwd_avg, rev_avg, fwd_peak;
  logic        sample_strobe, swr_trip, tx_inhibit;
  logic [11:0] f2_fwd_avg, f2_rev_avg, f2_fwd_peak;
  logic        f2_strobe, f2_trip, f2_inhibit;

  int checks = 0;
  int failures = 0;

  pa_swr_monitor #(
    .SAMPLE_DIV(16'd4), .AVG_SHIFT(2), .HOLD_SAMPLES(3), .DECAY_STEP(8),
    .FWD_MIN(12'd100), .TRIP_SHIFT(1), .TRIP_COUNT(4), .LOCKOUT_SAMPLES(5)
  ) u_dut (
    .clock(clock), .reset_n(reset_n), .ptt(ptt), .fwd_in(fwd_in), .rev_in(rev_in),
    .fwd_avg(fwd_avg), .rev_avg(rev_avg), .fwd_peak(fwd_peak),
    .sample_strobe(sample_strobe), .swr_trip(swr_trip), .tx_inhibit(tx_inhibit)
  );

  // Same settings except a raised forward-power floor.
  pa_swr_monitor #(
    .SAMPLE_DIV(16'd4), .AVG_SHIFT(2), .HOLD_SAMPLES(3), .DECAY_STEP(8),
    .FWD_MIN(12'd400), .TRIP_SHIFT(1), .TRIP_COUNT(4), .LOCKOUT_SAMPLES(5)
  ) u_fmin (
    .clock(clock), .reset_n(reset_n), .ptt(ptt), .fwd_in(fwd_in), .rev_in(rev_in),
    .fwd_avg(f2_fwd_avg), .rev_avg(f2_rev_avg), .fwd_peak(f2_fwd_peak),
    .sample_strobe(f2_strobe), .swr_trip(f2_trip), .tx_inhibit(f2_inhibit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_strobe();
    int n;
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!sample_strobe && n < 20);
    if (!sample_strobe) check("strobe_timeout", {31'd0, sample_strobe}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int n;
    logic seen, seen2, wrapped;
    logic [11:0] prev;

    // Reset: asynchronous clear, divider restart
    reset_n = 1'b0; ptt = 1'b1; fwd_in = 12'd2000; rev_in = 12'd1200;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) wait_strobe();
    check("pre_rst_avg", fwd_avg, 1156);
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("rst_fwd_avg", fwd_avg, 0);
    check("rst_rev_avg", rev_avg, 0);
    check("rst_fwd_peak", fwd_peak, 0);
    check("rst_strobe", sample_strobe, 0);
    check("rst_trip", swr_trip, 0);
    check("rst_inhibit", tx_inhibit, 0);
    @(negedge clock);
    reset_n = 1'b1;
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!sample_strobe && n < 10);
    check("rst_first_strobe", n, 4);

    // Averaging step response
    ptt = 1'b0; fwd_in = 12'd0; rev_in = 12'd0;
    do_reset();
    fwd_in = 12'd400;
    wait_strobe(); check("avg_1", fwd_avg, 100);
    wait_strobe(); check("avg_2", fwd_avg, 175);
    wait_strobe(); check("avg_3", fwd_avg, 231);
    wait_strobe(); check("avg_4", fwd_avg, 273);
    check("avg_rev", rev_avg, 0);
    repeat (40) wait_strobe();
    check("avg_settle", fwd_avg, 400);

    // Peak hold, decay and saturation
    fwd_in = 12'd1000; rev_in = 12'd0;
    do_reset();
    wait_strobe(); check("peak_capture", fwd_peak, 1000);
    fwd_in = 12'd0;
    for (int i = 1; i <= 3; i++) begin
      wait_strobe();
      check($sformatf("peak_hold_%0d", i), fwd_peak, 1000);
    end
    wait_strobe(); check("peak_decay_1", fwd_peak, 992);
    wait_strobe(); check("peak_decay_2", fwd_peak, 984);
    wrapped = 1'b0;
    prev = fwd_peak;
    for (int i = 0; i < 150; i++) begin
      wait_strobe();
      if (fwd_peak > prev) wrapped = 1'b1;
      prev = fwd_peak;
    end
    check("peak_floor", fwd_peak, 0);
    check("peak_no_wrap", wrapped, 0);
    fwd_in = 12'd13;
    wait_strobe(); check("peak_small", fwd_peak, 13);
    fwd_in = 12'd0;
    repeat (3) wait_strobe();
    wait_strobe(); check("peak_small_dec", fwd_peak, 5);
    wait_strobe(); check("peak_sat_1", fwd_peak, 0);
    wait_strobe(); check("peak_sat_2", fwd_peak, 0);

    // Trip on the fifth strobe
    ptt = 1'b1; fwd_in = 12'd2000; rev_in = 12'd1200;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      wait_strobe();
      check($sformatf("trip_%0d", i), swr_trip, (i == 5) ? 1 : 0);
      check($sformatf("trip_inh_%0d", i), tx_inhibit, (i == 5) ? 1 : 0);
    end

    // Lockout then return to TX via IDLE
    @(negedge clock); ptt = 1'b0;
    @(negedge clock); ptt = 1'b1;
    check("lock_trip_clr", swr_trip, 0);
    check("lock_inhibit", tx_inhibit, 1);
    for (int i = 1; i <= 5; i++) begin
      wait_strobe();
      check($sformatf("lock_tick_%0d", i), tx_inhibit, (i < 5) ? 1 : 0);
    end
    for (int i = 1; i <= 4; i++) begin
      wait_strobe();
      if (i == 1) check("tx_inhibit_low", tx_inhibit, 0);
      check($sformatf("retrip_%0d", i), swr_trip, (i == 4) ? 1 : 0);
    end

    // No trip with good SWR
    ptt = 1'b1; fwd_in = 12'd2000; rev_in = 12'd200;
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      wait_strobe();
      seen |= swr_trip | tx_inhibit;
    end
    check("nf_good_swr", seen, 0);

    // No trip below the forward-power floor
    ptt = 1'b1; fwd_in = 12'd300; rev_in = 12'd300;
    do_reset();
    seen = 1'b0; seen2 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      wait_strobe();
      seen  |= f2_trip | f2_inhibit;
      seen2 |= swr_trip;
    end
    check("nf_fmin", seen, 0);
    check("nf_fmin_ref_trips", seen2, 1);
    check("nf_fmin_avg", f2_fwd_avg, 300);
    check("nf_fmin_rev", f2_rev_avg, 300);
    check("nf_fmin_peak", f2_fwd_peak, 300);
    check("nf_fmin_strobe", f2_strobe, 1);

    // ptt toggling every 3 ticks keeps clearing the bad count
    ptt = 1'b0; fwd_in = 12'd2000; rev_in = 12'd1200;
    do_reset();
    repeat (12) wait_strobe();
    seen = 1'b0;
    for (int ph = 0; ph < 8; ph++) begin
      ptt = (ph % 2 == 0);
      for (int k = 0; k < 3; k++) begin
        wait_strobe();
        seen |= swr_trip | tx_inhibit;
      end
    end
    check("nf_ptt_toggle", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
